// File: rtl/clock_gen_pkg.sv
// ---------------------------------------------------------------------------
// clock_gen_pkg
//
// Purpose: shared constants and helpers for the processor clock phase
// generator (clock_phase_gen) and its period counter (div_counter).
//
// Contents:
//   CNT_W_DEFAULT : default width of the period counter and ratio fields.
//   DIV_MIN       : smallest divide ratio the generator will run at.
//   clamp_div()   : maps a requested ratio onto the legal range (0/1 -> 2).
// ---------------------------------------------------------------------------
package clock_gen_pkg;

    localparam int          CNT_W_DEFAULT = 4;
    localparam int unsigned DIV_MIN       = 2;

    // Ratios 0 and 1 cannot produce a clock with both a low and a high
    // phase, so they are promoted to the minimum ratio. The argument is
    // taken 32 bits wide so the helper works for any counter width.
    function automatic int unsigned clamp_div(input int unsigned ratio);
        return (ratio < DIV_MIN) ? DIV_MIN : ratio;
    endfunction

endpackage

// File: rtl/div_counter.sv
// ---------------------------------------------------------------------------
// div_counter
//
// Purpose: period counter for the processor clock generator. Counts
// 0 .. div-1 on enabled master-clock edges and wraps back to 0.
//
// Ports:
//   clock    in   master clock, rising-edge state updates
//   reset    in   asynchronous active-low reset (cnt -> 0)
//   enable   in   1 = advance, 0 = hold
//   div      in   ratio currently in force (always 2..2^CNT_W-1)
//   next_cnt out  value cnt takes at the next rising edge
//   wrap     out  cnt is at the last count of the period (cnt == div-1)
// ---------------------------------------------------------------------------
module div_counter
    import clock_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] next_cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    // The ratio only changes on a wrap edge, where cnt returns to 0, so
    // cnt can never be left above a newly installed, smaller ratio.
    assign wrap = (cnt == (div - CNT_W'(1)));

    always_comb begin
        next_cnt = cnt;
        if (enable) begin
            next_cnt = wrap ? '0 : (cnt + CNT_W'(1));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/clock_phase_gen.sv
// ---------------------------------------------------------------------------
// clock_phase_gen
//
// Purpose: divides the master clock down to the processor clock with a
// run-time selectable ratio, and provides per-count phase strobes, an
// end-of-period tick and an acknowledge for ratio changes. Ratio changes
// take effect only at a period boundary, so processor_clock never glitches.
//
// Ports:
//   clock           in   master clock, rising-edge state updates
//   reset           in   asynchronous active-low reset
//   enable          in   1 = advance the counter, 0 = hold all state
//   div_sel         in   requested divide ratio (0/1 treated as 2)
//   div_load        in   single-cycle request to capture div_sel
//   processor_clock out  divided clock: low ceil(D/2), high floor(D/2)
//   tick            out  high during the last master cycle of each period
//   phase_stb       out  one-hot, bit k high while the count equals k
//   div_active      out  ratio currently in force
//   load_ack        out  one-cycle pulse on the cycle a new ratio starts
//
// Ratio-change handshake: div_load is a request with no back-pressure; it
// is sampled on every rising edge (enabled or not) and the clamped div_sel
// overwrites any pending ratio, so the last request before a boundary
// wins. The pending ratio is installed on the first enabled wrap edge that
// sees it already pending; load_ack is high for exactly the cycle that
// follows that edge, i.e. the first cycle counted under the new ratio.
// A request landing on the wrap edge itself waits for the next wrap.
//
// Every output is a register loaded from the post-edge count and ratio,
// so outputs always agree with the internal count and no input reaches
// an output combinationally.
// ---------------------------------------------------------------------------
module clock_phase_gen
    import clock_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DIV_DEFAULT = 4,
    parameter int NUM_PHASES  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      div_sel,
    input  logic                  div_load,
    output logic                  processor_clock,
    output logic                  tick,
    output logic [NUM_PHASES-1:0] phase_stb,
    output logic [CNT_W-1:0]      div_active,
    output logic                  load_ack
);

    // -----------------------------------------------------------------
    // Ratio capture and application
    // -----------------------------------------------------------------
    logic [CNT_W-1:0] pending;
    logic             pending_valid;
    logic [CNT_W-1:0] sel_clamped;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] next_cnt;

    assign sel_clamped = CNT_W'(clamp_div(32'(div_sel)));

    // pending_valid is the registered flag, so a request arriving on the
    // wrap edge cannot be applied on that same edge.
    assign apply    = enable && wrap && pending_valid;
    assign div_next = apply ? pending : div_active;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending       <= CNT_W'(DIV_DEFAULT);
            pending_valid <= 1'b0;
            div_active    <= CNT_W'(DIV_DEFAULT);
        end else begin
            if (apply) begin
                div_active    <= pending;
                pending_valid <= 1'b0;
            end
            // Placed after the apply branch: a request on the apply edge
            // becomes the next pending ratio and keeps the flag set.
            if (div_load) begin
                pending       <= sel_clamped;
                pending_valid <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------
    // Period counter
    // -----------------------------------------------------------------
    div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .div      (div_active),
        .next_cnt (next_cnt),
        .wrap     (wrap)
    );

    // -----------------------------------------------------------------
    // Output decode from the post-edge count and ratio
    // -----------------------------------------------------------------
    logic [CNT_W-1:0]      high_start;
    logic                  pclk_next;
    logic                  tick_next;
    logic [NUM_PHASES-1:0] phase_next;

    // The high phase covers the last floor(D/2) counts of the period, so
    // an odd ratio spends the extra cycle low.
    assign high_start = div_next - (div_next >> 1);
    assign pclk_next  = (next_cnt >= high_start);
    assign tick_next  = (next_cnt == (div_next - CNT_W'(1)));

    // Strobes for counts at or above the ratio simply never match.
    always_comb begin
        phase_next = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            phase_next[k] = (next_cnt == CNT_W'(k));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            processor_clock <= 1'b0;
            tick            <= 1'b0;
            phase_stb       <= NUM_PHASES'(1);
            load_ack        <= 1'b0;
        end else begin
            // While disabled the decoded outputs are held and the
            // acknowledge is cleared so it is never stretched.
            load_ack <= apply;
            if (enable) begin
                processor_clock <= pclk_next;
                tick            <= tick_next;
                phase_stb       <= phase_next;
            end
        end
    end

endmodule

// File: tb/tb_clock_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_phase_gen
//
// Directed bench for clock_phase_gen (CNT_W=4, DIV_DEFAULT=4, NUM_PHASES=4).
// Outputs are sampled 1 ns after each rising edge; inputs change at that
// point so they are stable well before the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_phase_gen;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] div_sel;
    logic       div_load;
    logic       processor_clock;
    logic       tick;
    logic [3:0] phase_stb;
    logic [3:0] div_active;
    logic       load_ack;

    int tests_run = 0;
    int tests_failed = 0;

    clock_phase_gen #(
        .CNT_W       (4),
        .DIV_DEFAULT (4),
        .NUM_PHASES  (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .div_sel         (div_sel),
        .div_load        (div_load),
        .processor_clock (processor_clock),
        .tick            (tick),
        .phase_stb       (phase_stb),
        .div_active      (div_active),
        .load_ack        (load_ack)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic pc, input logic tk,
                              input logic [3:0] ph, input logic [3:0] da, input logic ack);
        chk({tag, ".pclk"},  32'(processor_clock), 32'(pc));
        chk({tag, ".tick"},  32'(tick),            32'(tk));
        chk({tag, ".phase"}, 32'(phase_stb),       32'(ph));
        chk({tag, ".div"},   32'(div_active),      32'(da));
        chk({tag, ".ack"},   32'(load_ack),        32'(ack));
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Hand tables indexed by count: bit c = expected value at count c.
    logic [3:0] pc4 = 4'b1100;
    logic [3:0] tk4 = 4'b1000;
    logic [5:0] pc6 = 6'b111000;
    logic [5:0] tk6 = 6'b100000;
    logic [4:0] pc5 = 5'b11000;
    logic [4:0] tk5 = 5'b10000;
    logic [1:0] pc2 = 2'b10;
    logic [1:0] tk2 = 2'b10;
    logic [3:0] ph_tab [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

    initial begin
        int c;
        reset    = 1'b1;
        enable   = 1'b0;
        div_sel  = 4'd0;
        div_load = 1'b0;
        #1 reset = 1'b0;
        #2;
        expect_out("reset", 1'b0, 1'b0, 4'h1, 4'd4, 1'b0);
        cyc();
        cyc();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;

        // Default ratio 4, 12 cycles
        for (int i = 1; i <= 12; i++) begin
            cyc();
            c = i % 4;
            expect_out($sformatf("d4_%0d", i), pc4[c], tk4[c], ph_tab[c], 4'd4, 1'b0);
        end

        // Load 6 at count 1: applies at the wrap from count 3
        cyc();
        expect_out("l6_c1", 1'b0, 1'b0, 4'h2, 4'd4, 1'b0);
        div_sel  = 4'd6;
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        expect_out("l6_c2", 1'b1, 1'b0, 4'h4, 4'd4, 1'b0);
        cyc();
        expect_out("l6_c3", 1'b1, 1'b1, 4'h8, 4'd4, 1'b0);
        cyc();
        expect_out("l6_wrap", 1'b0, 1'b0, 4'h1, 4'd6, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            c = i % 6;
            expect_out($sformatf("d6_%0d", i), pc6[c], tk6[c], ph_tab[c], 4'd6, 1'b0);
        end

        // Load 5 at count 0 of a ratio-6 period
        div_sel  = 4'd5;
        div_load = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            div_load = 1'b0;
            expect_out($sformatf("l5_c%0d", i), pc6[i], tk6[i], ph_tab[i], 4'd6, 1'b0);
        end
        cyc();
        expect_out("l5_wrap", 1'b0, 1'b0, 4'h1, 4'd5, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            c = i % 5;
            expect_out($sformatf("d5_%0d", i), pc5[c], tk5[c], ph_tab[c], 4'd5, 1'b0);
        end

        // Load 0 then 1 (both clamp to 2, last writer wins)
        div_sel  = 4'd0;
        div_load = 1'b1;
        cyc();
        expect_out("l01_c1", 1'b0, 1'b0, 4'h2, 4'd5, 1'b0);
        div_sel = 4'd1;
        cyc();
        div_load = 1'b0;
        expect_out("l01_c2", 1'b0, 1'b0, 4'h4, 4'd5, 1'b0);
        cyc();
        expect_out("l01_c3", 1'b1, 1'b0, 4'h8, 4'd5, 1'b0);
        cyc();
        expect_out("l01_c4", 1'b1, 1'b1, 4'h0, 4'd5, 1'b0);
        cyc();
        expect_out("l01_wrap", 1'b0, 1'b0, 4'h1, 4'd2, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            c = i % 2;
            expect_out($sformatf("d2_%0d", i), pc2[c], tk2[c], ph_tab[c], 4'd2, 1'b0);
        end

        // Back to ratio 4, then freeze at count 2 with a load pending
        div_sel  = 4'd4;
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        expect_out("l4_c1", 1'b1, 1'b1, 4'h2, 4'd2, 1'b0);
        cyc();
        expect_out("l4_wrap", 1'b0, 1'b0, 4'h1, 4'd4, 1'b1);
        cyc();
        expect_out("l4_c1b", 1'b0, 1'b0, 4'h2, 4'd4, 1'b0);
        cyc();
        expect_out("l4_c2", 1'b1, 1'b0, 4'h4, 4'd4, 1'b0);
        div_sel  = 4'd7;
        div_load = 1'b1;
        enable   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            div_load = 1'b0;
            expect_out($sformatf("hold_%0d", i), 1'b1, 1'b0, 4'h4, 4'd4, 1'b0);
        end
        enable = 1'b1;
        cyc();
        expect_out("resume_c3", 1'b1, 1'b1, 4'h8, 4'd4, 1'b0);
        cyc();
        expect_out("resume_wrap", 1'b0, 1'b0, 4'h1, 4'd7, 1'b1);
        cyc();
        expect_out("d7_c1", 1'b0, 1'b0, 4'h2, 4'd7, 1'b0);
        cyc();
        expect_out("d7_c2", 1'b0, 1'b0, 4'h4, 4'd7, 1'b0);

        // Reload of the same ratio is still applied and acknowledged
        div_sel  = 4'd7;
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        expect_out("same_c3", 1'b0, 1'b0, 4'h8, 4'd7, 1'b0);
        cyc();
        expect_out("same_c4", 1'b1, 1'b0, 4'h0, 4'd7, 1'b0);
        cyc();
        expect_out("same_c5", 1'b1, 1'b0, 4'h0, 4'd7, 1'b0);
        cyc();
        expect_out("same_c6", 1'b1, 1'b1, 4'h0, 4'd7, 1'b0);
        cyc();
        expect_out("same_wrap", 1'b0, 1'b0, 4'h1, 4'd7, 1'b1);

        // Asynchronous reset mid-period with a ratio pending
        cyc();
        expect_out("pre_rst_c1", 1'b0, 1'b0, 4'h2, 4'd7, 1'b0);
        div_sel  = 4'd3;
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        expect_out("pre_rst_c2", 1'b0, 1'b0, 4'h4, 4'd7, 1'b0);
        #3 reset = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 4'h1, 4'd4, 1'b0);
        cyc();
        expect_out("rst_held", 1'b0, 1'b0, 4'h1, 4'd4, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            c = i % 4;
            expect_out($sformatf("post_rst_%0d", i), pc4[c], tk4[c], ph_tab[c], 4'd4, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
